unaligned_ram: RTL and testbench
================================

UNALIGNED_RAM -- requirements
Module: unaligned_ram

Interface
REQ-001 Parameter abits, default 8, log2 of number of 32-bit words.
REQ-002 Parameter init_file, default "", initialisation file passed to raw_block_ram; empty means no init.
REQ-003 Parameter misalign, default 1, 1 = word-crossing accesses are split into two RAM cycles; 0 = misaligned accesses return an alignment error.
REQ-004 clk  input  1  sole clock; RAM and all state on rising edge.
REQ-005 rst  input  1  reset, asynchronous, active-high.
REQ-006 bus  axo_mem_bus.MEM  --  memory port: re, we, asize[1:0], addr, wdata[31:0] in; rdata[31:0], ready, error out.

Function
REQ-007 Storage SHALL be one raw_block_ram instance (2^abits words, 4 byte lanes, 1-cycle synchronous read), clocked by clk.
REQ-008 Byte address decomposes as word index W = addr[abits+1:2], offset O = addr[1:0]; higher address bits SHALL be ignored (aliasing).
REQ-009 Access size N = 1, 2, 4 bytes for asize 0, 1, 2; access crosses a word when O+N > 4.
REQ-010 FSM states: IDLE, SPLIT, RESP; reset state IDLE.
REQ-011 IDLE, no re/we: ready=0, no RAM write, stay IDLE.
REQ-012 IDLE, re or we, non-crossing legal access: RAM accesses word W this cycle (writes committed), next state RESP.
REQ-013 IDLE, crossing access with misalign=1: RAM accesses word W this cycle, next state SPLIT; SPLIT accesses word (W+1) mod 2^abits, latches word-W read data, next state RESP.
REQ-014 RESP: ready=1 for exactly one cycle, then IDLE; latency = 2 cycles non-crossing, 3 cycles crossing, measured from request to ready; back-to-back requests start in the cycle after ready.
REQ-015 Write lanes: 64-bit byte mask = ((1<<N)-1) << O, low 4 bits to word W, high 4 bits to word W+1; write data = wdata[8N-1:0] shifted left by 8*O across the 64-bit pair; bytes outside the mask SHALL be unmodified.
REQ-016 Read data: {word W+1, word W} shifted right by 8*O, truncated to N bytes, zero-extended to 32 bits (little-endian).
REQ-017 we and re both set: treated as write; rdata SHALL be 0 at ready.
REQ-018 Request inputs SHALL be sampled in IDLE only and held internally; deassertion or change of re/we/addr/wdata/asize before ready SHALL NOT abort or alter the operation.
REQ-019 asize=3 with re or we: no RAM write, RESP after 1 cycle, error=1, rdata=AXO_MEM_EASIZE.
REQ-020 misalign=0 and O not a multiple of N, with re or we: no RAM write, RESP after 1 cycle, error=1, rdata=AXO_MEM_EALIGN.
REQ-021 error SHALL be 0 except in RESP of an erroring access; rdata SHALL be 0 whenever ready=0.
REQ-022 Wrap-around: crossing access at W = 2^abits-1 SHALL use word 0 as second word.

Reset
REQ-023 rst=1 SHALL force state IDLE, ready=0, error=0, rdata=0 immediately, independent of clk.
REQ-024 rst mid-operation: a pending second-word write SHALL NOT occur; a first-word write already committed in IDLE stays; no ready is issued for the aborted request.
REQ-025 RAM contents SHALL NOT be cleared by reset.

Verification
REQ-026 Assert rst during idle and during SPLIT -> ready=0, error=0, rdata=0 within same cycle; after release, IDLE.
REQ-027 Word write 0x12345678 at 0x10, then word read 0x10 -> ready 2 cycles after each request, rdata=0x12345678, error=0.
REQ-028 Zeroed RAM, misalign=1, word write 0xAABBCCDD at 0x0E -> ready on 3rd cycle; word reads 0x0C -> 0xCCDD0000, 0x10 -> 0x0000AABB, 0x0E -> 0xAABBCCDD in 3 cycles.
REQ-029 abits=8, word write 0x11223344 at 0x3FD -> byte read 0x000 = 0x11, byte read 0x3FD = 0x44, word 1 unchanged.
REQ-030 misalign=0, halfword read at 0x01 -> ready after 1 cycle, error=1, rdata=AXO_MEM_EALIGN; asize=3 write -> error=1, rdata=AXO_MEM_EASIZE; RAM unchanged in both.
REQ-031 Crossing write at 0x0E with re/we dropped in SPLIT cycle -> both words still written, ready asserted once.

Source files
------------

// File: rtl/unaligned_ram.sv
// Byte-addressable 32-bit RAM front end: 1/2/4-byte accesses at any byte
// offset. An access that crosses a word boundary either takes two RAM cycles
// or is rejected as misaligned.

// Single-port block RAM: 2^abits words, 4 byte-lane write enables.
// Reads are registered and read-first.
module raw_block_ram #(
  parameter int unsigned abits     = 8,
  parameter string       init_file = ""
) (
  input  logic             clk,
  input  logic [abits-1:0] addr_i,
  input  logic [3:0]       be_i,
  input  logic [31:0]      wdata_i,
  output logic [31:0]      rdata_o
);
  localparam int unsigned Depth = 1 << abits;

  logic [31:0] mem_q [Depth];
  logic [31:0] rdata_q;

  // No preload image is applied in RTL; the name is carried so that builds
  // passing one elaborate unchanged.
  logic unused_init;
  assign unused_init = (init_file != "");

  // Byte-lane writes and one-cycle synchronous read of the addressed word
  always_ff @(posedge clk) begin
    for (int unsigned i = 0; i < 4; i++) begin
      if (be_i[i]) mem_q[addr_i][8*i +: 8] <= wdata_i[8*i +: 8];
    end
    rdata_q <= mem_q[addr_i];
  end

  assign rdata_o = rdata_q;
endmodule

module unaligned_ram #(
  parameter int unsigned abits     = 8,
  parameter string       init_file = "",
  parameter bit          misalign  = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        bus_re_i,
  input  logic        bus_we_i,
  input  logic [1:0]  bus_asize_i,
  input  logic [31:0] bus_addr_i,
  input  logic [31:0] bus_wdata_i,
  output logic [31:0] bus_rdata_o,
  output logic        bus_ready_o,
  output logic        bus_error_o
);
  localparam logic [31:0] AXO_MEM_EALIGN = 32'h0000_0001;
  localparam logic [31:0] AXO_MEM_EASIZE = 32'h0000_0002;

  typedef enum logic [1:0] {IDLE, SPLIT, RESP} state_e;

  state_e state_q, state_d;

  // Request held from IDLE through RESP
  logic             wr_q;
  logic             cross_q;
  logic             err_q;
  logic             esize_q;
  logic [1:0]       off_q;
  logic [31:0]      smask_q;
  logic [abits-1:0] word_q;
  logic [3:0]       hi_be_q;
  logic [31:0]      hi_data_q;
  logic [31:0]      lo_q;

  // Live request decode, only meaningful in IDLE
  logic [abits-1:0] req_word;
  logic [1:0]       req_off;
  logic [2:0]       req_n;
  logic [3:0]       req_lanes;
  logic [1:0]       req_amask;
  logic [31:0]      req_smask;
  logic             req_go;
  logic             req_cross;
  logic             req_esize;
  logic             req_ealign;
  logic [7:0]       req_bmask;
  logic [63:0]      req_wdata64;

  // RAM port
  logic [abits-1:0] ram_addr;
  logic [3:0]       ram_be;
  logic [31:0]      ram_wdata;
  logic [31:0]      ram_rdata;

  logic [63:0]      rd_pair;
  logic [31:0]      rd_shift;

  // Address bits above the RAM size alias onto the same words
  logic unused_addr_hi;
  assign unused_addr_hi = ^bus_addr_i[31:abits+2];

  raw_block_ram #(
    .abits     (abits),
    .init_file (init_file)
  ) u_ram (
    .clk     (clk),
    .addr_i  (ram_addr),
    .be_i    (ram_be),
    .wdata_i (ram_wdata),
    .rdata_o (ram_rdata)
  );

  // Decode size, lane mask, shifted write data and legality of the live request
  always_comb begin
    req_word  = bus_addr_i[abits+1:2];
    req_off   = bus_addr_i[1:0];
    req_go    = bus_re_i | bus_we_i;
    req_esize = (bus_asize_i == 2'd3);
    case (bus_asize_i)
      2'd0:    begin req_n = 3'd1; req_lanes = 4'b0001; req_amask = 2'b00; req_smask = 32'h0000_00ff; end
      2'd1:    begin req_n = 3'd2; req_lanes = 4'b0011; req_amask = 2'b01; req_smask = 32'h0000_ffff; end
      default: begin req_n = 3'd4; req_lanes = 4'b1111; req_amask = 2'b11; req_smask = 32'hffff_ffff; end
    endcase
    req_ealign  = !misalign && ((req_off & req_amask) != 2'b00);
    req_cross   = (3'(req_off) + req_n) > 3'd4;
    req_bmask   = 8'(req_lanes) << req_off;
    req_wdata64 = 64'(bus_wdata_i & req_smask) << {req_off, 3'b000};
  end

  // State register and request capture; RAM contents are not reset
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      wr_q      <= 1'b0;
      cross_q   <= 1'b0;
      err_q     <= 1'b0;
      esize_q   <= 1'b0;
      off_q     <= '0;
      smask_q   <= '0;
      word_q    <= '0;
      hi_be_q   <= '0;
      hi_data_q <= '0;
      lo_q      <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == IDLE && req_go) begin
        wr_q      <= bus_we_i;
        cross_q   <= req_cross;
        err_q     <= req_esize | req_ealign;
        esize_q   <= req_esize;
        off_q     <= req_off;
        smask_q   <= req_smask;
        word_q    <= req_word;
        hi_be_q   <= req_bmask[7:4];
        hi_data_q <= req_wdata64[63:32];
      end
      if (state_q == SPLIT) lo_q <= ram_rdata;
    end
  end

  // Next state and RAM drive: first word straight from the bus, second from the held request
  always_comb begin
    state_d   = state_q;
    ram_addr  = word_q;
    ram_be    = '0;
    ram_wdata = hi_data_q;
    case (state_q)
      IDLE: begin
        ram_addr  = req_word;
        ram_wdata = req_wdata64[31:0];
        if (req_go) begin
          if (req_esize || req_ealign) begin
            state_d = RESP;
          end else begin
            if (bus_we_i) ram_be = req_bmask[3:0];
            state_d = req_cross ? SPLIT : RESP;
          end
        end
      end
      SPLIT: begin
        ram_addr = word_q + 1'b1;
        if (wr_q) ram_be = hi_be_q;
        state_d = RESP;
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Response: {W+1, W} read pair shifted down by the byte offset, masked to size
  always_comb begin
    bus_ready_o = 1'b0;
    bus_error_o = 1'b0;
    bus_rdata_o = '0;
    rd_pair     = {ram_rdata, cross_q ? lo_q : ram_rdata};
    rd_shift    = 32'(rd_pair >> {off_q, 3'b000});
    if (state_q == RESP) begin
      bus_ready_o = 1'b1;
      if (err_q) begin
        bus_error_o = 1'b1;
        bus_rdata_o = esize_q ? AXO_MEM_EASIZE : AXO_MEM_EALIGN;
      end else if (!wr_q) begin
        bus_rdata_o = rd_shift & smask_q;
      end
    end
  end
endmodule

// File: tb/tb_unaligned_ram.sv
module tb_unaligned_ram;
  localparam logic [31:0] EALIGN = 32'h0000_0001;
  localparam logic [31:0] EASIZE = 32'h0000_0002;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // dut: misalign=1 ; dut0: misalign=0
  logic        re1 = 0, we1 = 0, rdy1, err1;
  logic [1:0]  asz1 = 0;
  logic [31:0] addr1 = 0, wd1 = 0, rd1;
  logic        re0 = 0, we0 = 0, rdy0, err0;
  logic [1:0]  asz0 = 0;
  logic [31:0] addr0 = 0, wd0 = 0, rd0;

  unaligned_ram #(.abits(8), .init_file(""), .misalign(1'b1)) dut (
    .clk(clk), .rst(rst), .bus_re_i(re1), .bus_we_i(we1), .bus_asize_i(asz1),
    .bus_addr_i(addr1), .bus_wdata_i(wd1), .bus_rdata_o(rd1),
    .bus_ready_o(rdy1), .bus_error_o(err1));

  unaligned_ram #(.abits(8), .init_file(""), .misalign(1'b0)) dut0 (
    .clk(clk), .rst(rst), .bus_re_i(re0), .bus_we_i(we0), .bus_asize_i(asz0),
    .bus_addr_i(addr0), .bus_wdata_i(wd0), .bus_rdata_o(rd0),
    .bus_ready_o(rdy0), .bus_error_o(err0));

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          lat;
  } exp_t;
  exp_t sb[$];

  // Byte-level reference memory per instance (1024 bytes each)
  logic [7:0] mdl [2][1024];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  function automatic int nbytes(input logic [1:0] asz);
    return (asz == 2'd0) ? 1 : (asz == 2'd1) ? 2 : 4;
  endfunction

  function automatic int baddr(input logic [31:0] a, input int i);
    return (int'(a[9:0]) + i) % 1024;
  endfunction

  task automatic model_write(input bit w, input logic [1:0] asz, input logic [31:0] a, input logic [31:0] d);
    for (int i = 0; i < nbytes(asz); i++) mdl[w][baddr(a, i)] = d[8*i +: 8];
  endtask

  function automatic logic [31:0] model_read(input bit w, input logic [1:0] asz, input logic [31:0] a);
    logic [31:0] r = '0;
    for (int i = 0; i < nbytes(asz); i++) r[8*i +: 8] = mdl[w][baddr(a, i)];
    return r;
  endfunction

  function automatic int exp_lat(input logic [1:0] asz, input logic [31:0] a);
    return ((int'(a[1:0]) + nbytes(asz)) > 4) ? 2 : 1;
  endfunction

  task automatic drive(input bit w, input logic re, input logic we, input logic [1:0] asz,
                       input logic [31:0] a, input logic [31:0] d);
    if (w) begin re1 = re; we1 = we; asz1 = asz; addr1 = a; wd1 = d; end
    else   begin re0 = re; we0 = we; asz0 = asz; addr0 = a; wd0 = d; end
  endtask

  function automatic logic obs_ready(input bit w); return w ? rdy1 : rdy0; endfunction
  function automatic logic obs_error(input bit w); return w ? err1 : err0; endfunction
  function automatic logic [31:0] obs_rdata(input bit w); return w ? rd1 : rd0; endfunction

  // One transaction: expectation queued at issue, request dropped (and bus
  // scrambled) after the sampling edge, response popped and checked on ready.
  task automatic req(input bit w, input logic re, input logic we, input logic [1:0] asz,
                     input logic [31:0] a, input logic [31:0] d,
                     input logic [31:0] erd, input logic eerr, input int elat, input string tag);
    exp_t e;
    int lat;
    e.rdata = erd; e.err = eerr; e.lat = elat;
    sb.push_back(e);
    @(negedge clk);
    drive(w, re, we, asz, a, d);
    @(negedge clk);
    drive(w, 1'b0, 1'b0, 2'($urandom), $urandom, $urandom);
    lat = 1;
    while (!obs_ready(w) && lat < 8) begin
      @(negedge clk);
      lat++;
    end
    e = sb.pop_front();
    chk({tag, " ready"},   32'(obs_ready(w)), 32'd1);
    chk({tag, " latency"}, 32'(lat),          32'(e.lat));
    chk({tag, " rdata"},   obs_rdata(w),      e.rdata);
    chk({tag, " error"},   32'(obs_error(w)), 32'(e.err));
    @(negedge clk);
    chk({tag, " ready pulse"}, 32'(obs_ready(w)), 32'd0);
    chk({tag, " idle rdata"},  obs_rdata(w),      32'd0);
  endtask

  task automatic wr(input bit w, input logic [1:0] asz, input logic [31:0] a, input logic [31:0] d, input string tag);
    model_write(w, asz, a, d);
    req(w, 1'b0, 1'b1, asz, a, d, 32'd0, 1'b0, exp_lat(asz, a), tag);
  endtask

  task automatic rd(input bit w, input logic [1:0] asz, input logic [31:0] a, input string tag);
    req(w, 1'b1, 1'b0, asz, a, $urandom, model_read(w, asz, a), 1'b0, exp_lat(asz, a), tag);
  endtask

  initial begin
    logic [31:0] zaddr [10] = '{32'h000, 32'h004, 32'h008, 32'h00C, 32'h010,
                                32'h014, 32'h02C, 32'h030, 32'h3FC, 32'h018};
    for (int b = 0; b < 1024; b++) begin mdl[0][b] = 8'h00; mdl[1][b] = 8'h00; end

    // Reset state
    #1;
    chk("reset ready", 32'(rdy1), 32'd0);
    chk("reset error", 32'(err1), 32'd0);
    chk("reset rdata", rd1, 32'd0);
    @(negedge clk); @(negedge clk);
    rst = 1'b0;

    // Known contents for every word read later
    for (int k = 0; k < 10; k++) wr(1'b1, 2'd2, zaddr[k], 32'h0, "zero");
    wr(1'b0, 2'd2, 32'h010, 32'h0, "zero0");

    // Crossing word write into zeroed words, then reads around it
    wr(1'b1, 2'd2, 32'h00E, 32'hAABBCCDD, "xwrite 0E");
    rd(1'b1, 2'd2, 32'h00C, "rd 0C");
    rd(1'b1, 2'd2, 32'h010, "rd 10");
    rd(1'b1, 2'd2, 32'h00E, "xread 0E");

    // Aligned word write/read
    wr(1'b1, 2'd2, 32'h010, 32'h12345678, "wr 10");
    rd(1'b1, 2'd2, 32'h010, "rd 10b");
    rd(1'b1, 2'd2, 32'h1010, "alias rd 1010");

    // Byte/halfword mix, including a crossing halfword
    wr(1'b1, 2'd0, 32'h011, 32'hFFFFFF9A, "byte wr 11");
    wr(1'b1, 2'd1, 32'h013, 32'h0000BEEF, "half xwr 13");
    rd(1'b1, 2'd2, 32'h010, "rd 10c");
    rd(1'b1, 2'd2, 32'h014, "rd 14");
    rd(1'b1, 2'd1, 32'h013, "half xrd 13");
    rd(1'b1, 2'd0, 32'h012, "byte rd 12");
    rd(1'b1, 2'd1, 32'h012, "half rd 12");

    // Wrap from the last word to word 0
    wr(1'b1, 2'd2, 32'h3FD, 32'h11223344, "wrap wr 3FD");
    rd(1'b1, 2'd0, 32'h000, "wrap byte 000");
    rd(1'b1, 2'd0, 32'h3FD, "wrap byte 3FD");
    rd(1'b1, 2'd2, 32'h004, "word1 intact");
    rd(1'b1, 2'd2, 32'h3FF, "wrap xrd 3FF");

    // re and we together behave as a write
    model_write(1'b1, 2'd1, 32'h008, 32'h0000C0DE);
    req(1'b1, 1'b1, 1'b1, 2'd1, 32'h008, 32'h0000C0DE, 32'd0, 1'b0, 1, "re+we");
    rd(1'b1, 2'd2, 32'h008, "rd 08");

    // Illegal size
    req(1'b1, 1'b1, 1'b0, 2'd3, 32'h010, 32'h0, EASIZE, 1'b1, 1, "esize rd");

    // Asynchronous reset while idle
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("idle rst ready", 32'(rdy1), 32'd0);
    chk("idle rst error", 32'(err1), 32'd0);
    chk("idle rst rdata", rd1, 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // Asynchronous reset during SPLIT: first word committed, second not
    @(negedge clk);
    drive(1'b1, 1'b0, 1'b1, 2'd2, 32'h02E, 32'hCAFEF00D);
    @(posedge clk);
    #1;
    drive(1'b1, 1'b0, 1'b0, 2'd0, 32'h0, 32'h0);
    model_write(1'b1, 2'd1, 32'h02E, 32'h0000F00D);
    rst = 1'b1;
    #1;
    chk("split rst ready", 32'(rdy1), 32'd0);
    chk("split rst error", 32'(err1), 32'd0);
    chk("split rst rdata", rd1, 32'd0);
    @(negedge clk); @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("no ready after abort", 32'(rdy1), 32'd0);
    rd(1'b1, 2'd2, 32'h02C, "aborted first word");
    rd(1'b1, 2'd2, 32'h030, "aborted second word");

    // misalign=0 instance: errors leave RAM untouched
    wr(1'b0, 2'd2, 32'h010, 32'h55667788, "m0 wr 10");
    req(1'b0, 1'b1, 1'b0, 2'd1, 32'h001, 32'h0, EALIGN, 1'b1, 1, "m0 ealign rd");
    req(1'b0, 1'b0, 1'b1, 2'd3, 32'h010, 32'hFFFFFFFF, EASIZE, 1'b1, 1, "m0 esize wr");
    req(1'b0, 1'b0, 1'b1, 2'd2, 32'h012, 32'hFFFFFFFF, EALIGN, 1'b1, 1, "m0 ealign wr");
    rd(1'b0, 2'd2, 32'h010, "m0 rd 10");
    rd(1'b0, 2'd1, 32'h012, "m0 half rd 12");

    chk("scoreboard drained", 32'(sb.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
